// File: rtl/lc3b_types.sv
//------------------------------------------------------------------------------
// lc3b_types : shared LC-3b widths plus the L2 arbiter state and port-select types
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cache_line;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } lc3b_l2arb_state;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } lc3b_port_sel;

endpackage

`default_nettype wire

// File: rtl/perf_counter16.sv
//------------------------------------------------------------------------------
// perf_counter16 : 16-bit enable-increment event counter, wraps 0xFFFF -> 0
// Revision       : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module perf_counter16
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    output lc3b_word count
);

    lc3b_word r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_count <= '0;
        else if (en)
            r_count <= r_count + 16'd1;
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/l2_arbiter.sv
//------------------------------------------------------------------------------
// l2_arbiter : round-robin serialiser of I-cache and D-cache misses onto the L2
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module l2_arbiter
    import lc3b_types::*;
(
    input  logic           clk,
    input  logic           rst,
    input  lc3b_word       i_address,
    input  logic           i_read,
    output lc3b_cache_line i_rdata,
    output logic           i_resp,
    input  lc3b_word       d_address,
    input  lc3b_cache_line d_wdata,
    input  logic           d_read,
    input  logic           d_write,
    output lc3b_cache_line d_rdata,
    output logic           d_resp,
    output lc3b_word       l2_address,
    output lc3b_cache_line l2_wdata,
    output logic           l2_read,
    output logic           l2_write,
    input  lc3b_cache_line l2_rdata,
    input  logic           l2_resp,
    output lc3b_word       arb_conflicts,
    output lc3b_word       i_grants,
    output lc3b_word       d_grants
);

    lc3b_l2arb_state r_state;
    lc3b_port_sel    r_last_grant;
    lc3b_word        r_address;
    lc3b_cache_line  r_wdata;
    logic            r_read;
    logic            r_write;

    logic w_idle;
    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_conflict;

    assign w_idle     = (r_state == IDLE);
    assign w_i_req    = i_read;
    assign w_d_req    = d_read | d_write;
    assign w_conflict = w_idle & w_i_req & w_d_req;
    // On a tie the port that was not served most recently wins.
    assign w_grant_i  = w_idle & w_i_req & (~w_d_req | (r_last_grant == PORT_D));
    assign w_grant_d  = w_idle & w_d_req & (~w_i_req | (r_last_grant == PORT_I));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_D;
            r_address    <= '0;
            r_wdata      <= '0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state   <= SERVE_I;
                        r_address <= i_address;
                        r_wdata   <= '0;
                        r_read    <= 1'b1;
                        r_write   <= 1'b0;
                    end else if (w_grant_d) begin
                        // Read and write together is forwarded as a write.
                        r_state   <= SERVE_D;
                        r_address <= d_address;
                        r_wdata   <= d_wdata;
                        r_read    <= d_read & ~d_write;
                        r_write   <= d_write;
                    end
                end
                SERVE_I: begin
                    if (l2_resp) begin
                        r_state      <= IDLE;
                        r_last_grant <= PORT_I;
                        r_read       <= 1'b0;
                        r_write      <= 1'b0;
                    end
                end
                SERVE_D: begin
                    if (l2_resp) begin
                        r_state      <= IDLE;
                        r_last_grant <= PORT_D;
                        r_read       <= 1'b0;
                        r_write      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign l2_address = r_address;
    assign l2_wdata   = r_wdata;
    assign l2_read    = r_read;
    assign l2_write   = r_write;

    assign i_rdata = l2_rdata;
    assign d_rdata = l2_rdata;
    assign i_resp  = (r_state == SERVE_I) & l2_resp;
    assign d_resp  = (r_state == SERVE_D) & l2_resp;

    perf_counter16 u_conflict_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_conflict),
        .count (arb_conflicts)
    );

    perf_counter16 u_i_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_grant_i),
        .count (i_grants)
    );

    perf_counter16 u_d_grant_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (w_grant_d),
        .count (d_grants)
    );

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
//------------------------------------------------------------------------------
// tb_l2_arbiter : directed stimulus with a response scoreboard for l2_arbiter
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  i_address, d_address, l2_address;
    logic [127:0] i_rdata, d_rdata, d_wdata, l2_wdata, l2_rdata;
    logic         i_read, i_resp, d_read, d_write, d_resp;
    logic         l2_read, l2_write, l2_resp;
    logic [15:0]  arb_conflicts, i_grants, d_grants;

    typedef struct {
        bit           port;   // 0 = I, 1 = D
        logic [127:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [127:0] C_LINE_A = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    localparam logic [127:0] C_LINE_B = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] C_LINE_C = 128'hCAFE_F00D_0000_0000_0000_0000_1234_5678;

    always #5 clk = ~clk;

    l2_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_rdata       (i_rdata),
        .i_resp        (i_resp),
        .d_address     (d_address),
        .d_wdata       (d_wdata),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_rdata       (d_rdata),
        .d_resp        (d_resp),
        .l2_address    (l2_address),
        .l2_wdata      (l2_wdata),
        .l2_read       (l2_read),
        .l2_write      (l2_write),
        .l2_rdata      (l2_rdata),
        .l2_resp       (l2_resp),
        .arb_conflicts (arb_conflicts),
        .i_grants      (i_grants),
        .d_grants      (d_grants)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every resp pulse must match the oldest expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (i_resp || d_resp) begin
                checks++;
                if (i_resp && d_resp) begin
                    errors++;
                    $display("FAIL resp_both: got i_resp=1 d_resp=1 expected one");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
                end else begin
                    e = exp_q.pop_front();
                    if (d_resp !== e.port) begin
                        errors++;
                        $display("FAIL resp_port: got d_resp=%0b expected port %0d", d_resp, e.port);
                    end else if ((e.port ? d_rdata : i_rdata) !== e.data) begin
                        errors++;
                        $display("FAIL resp_data: got %h expected %h", e.port ? d_rdata : i_rdata, e.data);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        l2_resp = 1'b0; l2_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_grant(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(l2_read || l2_write) && n < 10);
        if (!(l2_read || l2_write)) begin
            checks++; errors++;
            $display("FAIL %s: got no L2 request expected one within 10 cycles", name);
        end
    endtask

    // Return one L2 line; the expected response is queued for the monitor.
    task automatic l2_return(input logic [127:0] data, input bit port, input bit drop);
        exp_t e;
        @(posedge clk);
        #1;
        e.port = port; e.data = data;
        exp_q.push_back(e);
        l2_rdata = data;
        l2_resp  = 1'b1;
        @(posedge clk);
        #1 l2_resp = 1'b0;
        if (drop) begin
            i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        end
    endtask

    initial begin
        i_address = '0; d_address = '0; d_wdata = '0;
        do_reset();
        @(negedge clk);
        check("rst_l2_read",   l2_read,  0);
        check("rst_l2_write",  l2_write, 0);
        check("rst_conflicts", arb_conflicts, 0);
        check("rst_i_grants",  i_grants, 0);
        check("rst_d_grants",  d_grants, 0);

        // Single I-cache read
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 16'h1230;
        wait_grant("i_grant");
        check("i_l2_read",  l2_read,  1);
        check("i_l2_write", l2_write, 0);
        check("i_l2_addr",  l2_address, 16'h1230);
        l2_return(C_LINE_A, 1'b0, 1'b1);
        @(negedge clk);
        check("i_grants_1", i_grants, 1);

        // D-cache writeback, with wdata changing after the grant
        @(posedge clk); #1;
        d_write = 1'b1; d_address = 16'h8840; d_wdata = C_LINE_B;
        wait_grant("d_grant");
        check("d_l2_write", l2_write, 1);
        check("d_l2_read",  l2_read,  0);
        check("d_l2_addr",  l2_address, 16'h8840);
        @(posedge clk); #1 d_wdata = C_LINE_C; d_address = 16'h0004;
        @(negedge clk);
        check("d_l2_wdata_held", l2_wdata, C_LINE_B);
        check("d_l2_addr_held",  l2_address, 16'h8840);
        l2_return(C_LINE_C, 1'b1, 1'b1);
        @(negedge clk);
        check("d_grants_1", d_grants, 1);
        check("i_grants_kept", i_grants, 1);

        // Tie after reset: I first, then D on the repeated tie
        do_reset();
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 16'h1111;
        d_read = 1'b1; d_address = 16'h2222;
        wait_grant("tie1_grant");
        check("tie1_addr",      l2_address, 16'h1111);
        check("tie1_conflicts", arb_conflicts, 1);
        l2_return(C_LINE_A, 1'b0, 1'b0);
        wait_grant("tie2_grant");
        check("tie2_addr",      l2_address, 16'h2222);
        check("tie2_l2_read",   l2_read, 1);
        check("tie2_conflicts", arb_conflicts, 2);
        l2_return(C_LINE_B, 1'b1, 1'b1);
        @(negedge clk);
        check("tie_i_grants", i_grants, 1);
        check("tie_d_grants", d_grants, 1);

        // Reset in the middle of a D write
        @(posedge clk); #1;
        d_write = 1'b1; d_address = 16'h4000; d_wdata = C_LINE_C;
        wait_grant("rst_mid_grant");
        check("rst_mid_write_before", l2_write, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_write",     l2_write, 0);
        check("rst_mid_conflicts", arb_conflicts, 0);
        check("rst_mid_d_grants",  d_grants, 0);
        check("rst_mid_i_grants",  i_grants, 0);
        d_write = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_idle", l2_write, 0);

        // Grant counter wrap
        force dut.u_i_grant_cnt.r_count = 16'hFFFF;
        @(negedge clk);
        release dut.u_i_grant_cnt.r_count;
        @(negedge clk);
        check("wrap_preload", i_grants, 16'hFFFF);
        @(posedge clk); #1;
        i_read = 1'b1; i_address = 16'h0FF0;
        wait_grant("wrap_grant");
        check("wrap_i_grants", i_grants, 16'h0000);
        l2_return(C_LINE_C, 1'b0, 1'b1);

        // Spurious L2 response while idle
        @(posedge clk); #1;
        l2_rdata = C_LINE_B; l2_resp = 1'b1;
        @(negedge clk);
        check("spur_i_resp", i_resp, 0);
        check("spur_d_resp", d_resp, 0);
        @(posedge clk); #1 l2_resp = 1'b0;
        @(negedge clk);
        check("spur_i_grants",  i_grants, 0);
        check("spur_d_grants",  d_grants, 0);
        check("spur_conflicts", arb_conflicts, 0);
        check("spur_l2_read",   l2_read, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
